// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join delay sequencer: FSM state encoding and delay word.
package fork_join_pkg;

  localparam int unsigned DLY_W = 8;

  typedef logic [DLY_W-1:0] dly_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    FORK = 2'd2,
    POST = 2'd3
  } state_t;

endpackage

// File: rtl/fork_join_sched_if.sv
// Control/config bus of the sequencer: start/abort and delays in, busy and phase pulses out.
interface fork_join_sched_if
  import fork_join_pkg::*;
#(
  parameter int unsigned W = DLY_W
);

  logic         start;
  logic         abort;
  logic [W-1:0] pre_dly;
  logic [W-1:0] a_dly;
  logic [W-1:0] b_dly;
  logic [W-1:0] post_dly;
  logic         busy;
  logic         pre_fire;
  logic         a_fire;
  logic         b_fire;
  logic         done;

  modport master (
    output start, abort, pre_dly, a_dly, b_dly, post_dly,
    input  busy, pre_fire, a_fire, b_fire, done
  );

  modport slave (
    input  start, abort, pre_dly, a_dly, b_dly, post_dly,
    output busy, pre_fire, a_fire, b_fire, done
  );

endinterface

// File: rtl/dly_branch.sv
// One timed branch of the fork: down-counter, registered completion pulse and sticky done flag.
module dly_branch
  import fork_join_pkg::*;
#(
  parameter int unsigned W = DLY_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic         abort,
  input  logic [W-1:0] value,
  output logic         fire,
  output logic         done,
  output logic         hit_c
);

  logic [W-1:0] cnt;

  // Branch completes on this edge; the top uses it to join in the same cycle.
  assign hit_c = en & ~done & (cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      fire <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      fire <= 1'b0;
    end else if (load) begin
      cnt  <= value;
      done <= 1'b0;
      fire <= 1'b0;
    end else begin
      fire <= hit_c;
      if (hit_c) begin
        done <= 1'b1;
      end else if (en && !done) begin
        cnt <= cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// Sequencer: pre delay, fork of two timed branches, join, post delay; one-cycle pulse per phase.
module fork_join_sched
  import fork_join_pkg::*;
#(
  parameter int unsigned W = DLY_W
) (
  input  logic              clk,
  input  logic              rstn,
  fork_join_sched_if.slave  bus
);

  state_t       state, state_d;
  logic [W-1:0] cnt, cnt_d;
  logic [W-1:0] a_val, b_val, q_val;
  logic         busy_q, busy_d;
  logic         pre_fire_q, pre_fire_d;
  logic         done_q, done_d;
  logic         cap_en, load_ab, en_ab, abort_run;
  logic         a_hit_c, b_hit_c, a_done, b_done;
  logic         cnt_zero, join_c;

  assign cnt_zero  = (cnt == '0);
  assign abort_run = bus.abort & (state != IDLE);
  assign join_c    = (a_done | a_hit_c) & (b_done | b_hit_c);

  assign bus.busy     = busy_q;
  assign bus.pre_fire = pre_fire_q;
  assign bus.done     = done_q;

  // State and phase registers; delays are captured only when a run is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      a_val      <= '0;
      b_val      <= '0;
      q_val      <= '0;
      busy_q     <= 1'b0;
      pre_fire_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      busy_q     <= busy_d;
      pre_fire_q <= pre_fire_d;
      done_q     <= done_d;
      if (cap_en) begin
        a_val <= bus.a_dly;
        b_val <= bus.b_dly;
        q_val <= bus.post_dly;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.start && !bus.abort) state_d = PRE;
      PRE: begin
        if (bus.abort)     state_d = IDLE;
        else if (cnt_zero) state_d = FORK;
      end
      FORK: begin
        if (bus.abort)   state_d = IDLE;
        else if (join_c) state_d = POST;
      end
      POST: begin
        if (bus.abort)     state_d = IDLE;
        else if (cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt;
    busy_d     = busy_q;
    pre_fire_d = 1'b0;
    done_d     = 1'b0;
    cap_en     = 1'b0;
    load_ab    = 1'b0;
    en_ab      = (state == FORK);
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cap_en = 1'b1;
          cnt_d  = bus.pre_dly;
          busy_d = 1'b1;
        end
      end
      PRE: begin
        if (bus.abort) begin
          busy_d = 1'b0;
        end else if (cnt_zero) begin
          pre_fire_d = 1'b1;
          load_ab    = 1'b1;
        end else begin
          cnt_d = cnt - W'(1);
        end
      end
      FORK: begin
        if (bus.abort)   busy_d = 1'b0;
        else if (join_c) cnt_d  = q_val;
      end
      POST: begin
        if (bus.abort) begin
          busy_d = 1'b0;
        end else if (cnt_zero) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt - W'(1);
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  dly_branch #(.W(W)) u_branch_a (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load_ab),
    .en    (en_ab),
    .abort (abort_run),
    .value (a_val),
    .fire  (bus.a_fire),
    .done  (a_done),
    .hit_c (a_hit_c)
  );

  dly_branch #(.W(W)) u_branch_b (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load_ab),
    .en    (en_ab),
    .abort (abort_run),
    .value (b_val),
    .fire  (bus.b_fire),
    .done  (b_done),
    .hit_c (b_hit_c)
  );

endmodule

// File: tb/tb_fork_join_sched.sv
// Randomized + directed bench for fork_join_sched against an event-time reference model.
module tb_fork_join_sched;
  import fork_join_pkg::*;

  logic clk;
  logic rstn;
  int   vecs;
  int   errs;
  int   ge;

  fork_join_sched_if #(.W(DLY_W)) bus ();

  fork_join_sched #(.W(DLY_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a run is a set of absolute edge numbers derived from P, A, B, Q.
  bit m_busy;
  int t_pre, t_a, t_b, t_done;
  bit exp_busy, exp_pre, exp_a, exp_b, exp_done;
  int ev_pre, ev_a, ev_b, ev_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, ge, got, exp);
    end
  endtask

  function automatic void model_step();
    int p, a, b, q;
    exp_pre  = 1'b0;
    exp_a    = 1'b0;
    exp_b    = 1'b0;
    exp_done = 1'b0;
    if (!rstn) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (bus.start && !bus.abort) begin
        p = int'(bus.pre_dly);
        a = int'(bus.a_dly);
        b = int'(bus.b_dly);
        q = int'(bus.post_dly);
        m_busy = 1'b1;
        t_pre  = ge + p + 1;
        t_a    = ge + p + a + 2;
        t_b    = ge + p + b + 2;
        t_done = ge + p + ((a > b) ? a : b) + q + 3;
      end
    end else if (bus.abort) begin
      m_busy = 1'b0;
    end else begin
      exp_pre  = (ge == t_pre);
      exp_a    = (ge == t_a);
      exp_b    = (ge == t_b);
      exp_done = (ge == t_done);
      if (ge == t_done) m_busy = 1'b0;
    end
    exp_busy = m_busy;
  endfunction

  task automatic cycle();
    @(posedge clk);
    ge++;
    model_step();
    #1;
    chk("busy",     32'(bus.busy),     32'(exp_busy));
    chk("pre_fire", 32'(bus.pre_fire), 32'(exp_pre));
    chk("a_fire",   32'(bus.a_fire),   32'(exp_a));
    chk("b_fire",   32'(bus.b_fire),   32'(exp_b));
    chk("done",     32'(bus.done),     32'(exp_done));
    if (bus.pre_fire) ev_pre  = ge;
    if (bus.a_fire)   ev_a    = ge;
    if (bus.b_fire)   ev_b    = ge;
    if (bus.done)     ev_done = ge;
  endtask

  task automatic set_dly(input int p, input int a, input int b, input int q);
    bus.pre_dly  = DLY_W'(p);
    bus.a_dly    = DLY_W'(a);
    bus.b_dly    = DLY_W'(b);
    bus.post_dly = DLY_W'(q);
  endtask

  // Start a run at the next edge, then scramble the delay inputs to prove they were captured.
  task automatic launch(input int p, input int a, input int b, input int q, output int s);
    set_dly(p, a, b, q);
    ev_pre = -1000; ev_a = -1000; ev_b = -1000; ev_done = -1000;
    bus.start = 1'b1;
    cycle();
    s = ge;
    bus.start = 1'b0;
    set_dly(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic lat_chk(input string tag, input int s, input int lp, input int la,
                         input int lb, input int ld);
    chk({tag, "_pre"},  32'(ev_pre - s),  32'(lp));
    chk({tag, "_a"},    32'(ev_a - s),    32'(la));
    chk({tag, "_b"},    32'(ev_b - s),    32'(lb));
    chk({tag, "_done"}, 32'(ev_done - s), 32'(ld));
  endtask

  initial begin
    int s0;
    vecs = 0; errs = 0; ge = 0; m_busy = 1'b0;
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_dly(0, 0, 0, 0);

    // Reset then idle.
    repeat (3) cycle();
    rstn = 1'b1;
    repeat (10) cycle();

    // Nominal run.
    launch(0, 10, 15, 20, s0);
    repeat (45) cycle();
    lat_chk("nom", s0, 1, 12, 17, 38);

    // All-zero delays, equal branches.
    launch(0, 0, 0, 0, s0);
    repeat (6) cycle();
    lat_chk("zero", s0, 1, 2, 2, 3);

    // Abort sampled at edge 15, new start at edge 20.
    launch(0, 10, 15, 20, s0);
    repeat (14) cycle();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (4) cycle();
    chk("abort_no_b",    32'(ev_b),    -32'sd1000);
    chk("abort_no_done", 32'(ev_done), -32'sd1000);
    launch(0, 10, 15, 20, s0);
    repeat (45) cycle();
    lat_chk("after_abort", s0, 1, 12, 17, 38);

    // Start while busy ignored, then start held high gives back-to-back runs.
    launch(0, 10, 15, 20, s0);
    repeat (4) cycle();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (24) cycle();
    set_dly(0, 10, 15, 20);
    bus.start = 1'b1;
    repeat (10) cycle();
    chk("b2b_done1", 32'(ev_done - s0), 32'd38);
    bus.start = 1'b0;
    repeat (40) cycle();
    chk("b2b_done2", 32'(ev_done - s0), 32'd77);

    // Async reset mid-run.
    launch(0, 10, 15, 20, s0);
    repeat (13) cycle();
    #2 rstn = 1'b0;
    #1;
    m_busy = 1'b0;
    chk("arst_busy", 32'(bus.busy),     32'd0);
    chk("arst_pre",  32'(bus.pre_fire), 32'd0);
    chk("arst_a",    32'(bus.a_fire),   32'd0);
    chk("arst_b",    32'(bus.b_fire),   32'd0);
    chk("arst_done", 32'(bus.done),     32'd0);
    repeat (2) cycle();
    rstn = 1'b1;
    repeat (3) cycle();
    launch(0, 10, 15, 20, s0);
    repeat (45) cycle();
    lat_chk("after_arst", s0, 1, 12, 17, 38);

    // Maximum delays: each phase takes 2^W cycles.
    launch(255, 255, 1, 255, s0);
    repeat (775) cycle();
    lat_chk("max", s0, 256, 512, 258, 768);

    // Random traffic: random start/abort pokes with random delays every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.abort = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0)
        set_dly(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
      else
        set_dly(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      cycle();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fork_join_sched.md
Name: fork_join_sched

Overview:
- Hardware sequencer for one run of a fixed sequence: a sequential delay phase, then two parallel timed branches (fork), a join that waits for both, then a final sequential delay.
- Each phase completion is reported as a one-cycle event pulse, so downstream register loads fire at the programmed times.
- Sits between a control/config source (delays plus start) and the datapath registers it times.

Parameters:
- W, 8, width of every delay field and internal down-counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- pre_dly  input  W  pre-phase delay P.
- a_dly  input  W  branch A delay A.
- b_dly  input  W  branch B delay B.
- post_dly  input  W  post-phase delay Q.
- busy  output  1  run in progress.
- pre_fire  output  1  one-cycle pulse at end of pre phase.
- a_fire  output  1  one-cycle pulse when branch A completes.
- b_fire  output  1  one-cycle pulse when branch B completes.
- done  output  1  one-cycle pulse at end of post phase (run complete).

Behaviour:
- All outputs are registered. On reset: state IDLE, all outputs 0, counters 0, branch-done flags 0.
- "Edge k" means the k-th rising clk edge after the edge at which start was accepted (edge 0). A pulse "at edge k" is high from edge k to edge k+1.
- FSM states: IDLE, PRE, FORK, POST.
- IDLE:
  - start=1 and abort=0 -> go to PRE at edge 0.
  - At the same edge: capture P, A, B and Q into internal registers, load the pre-counter with P, set busy=1.
  - Delay inputs are ignored after capture.
- PRE:
  - Each edge: if cnt==0 -> pre_fire=1, load cntA=A and cntB=B, clear both done flags, go to FORK; else cnt-1.
  - PRE lasts P+1 cycles; pre_fire occurs at edge P+1.
- FORK: each branch is independent.
  - If its done flag=0 and its cnt==0 -> fire the branch pulse and set its done flag.
  - Else, if not done, decrement.
  - A branch fires at (fork entry edge)+A+1, B at (fork entry edge)+B+1.
  - A==B: both pulses fire on the same edge.
  - Join: on the edge where both flags are (or become) set -> load cnt=Q and go to POST. FORK lasts max(A,B)+1 cycles.
- POST:
  - Each edge: if cnt==0 -> done=1, busy=0, go to IDLE; else cnt-1.
  - Total run: done at edge P+max(A,B)+Q+3.
- start while busy: ignored, with no queuing.
- done and a new start on adjacent cycles: start is accepted on the edge after done (the edge at which the FSM sits in IDLE), giving back-to-back runs with one idle cycle.
- abort=1 in any state other than IDLE:
  - Next edge: go to IDLE, busy=0, and all pulses that would have fired on that edge are suppressed.
  - done is not asserted.
- abort and start both high in IDLE: the start is not accepted.
- Delay value 0 is legal: that phase takes 1 cycle. Delay 2^W-1 takes 2^W cycles with no wrap error.
- Counters only decrement from nonzero values; no wrap-around occurs.
- Async reset mid-run: immediate return to IDLE, all outputs 0 without waiting for a clock edge.

Decomposition:
- Shared package fork_join_pkg holds:
  - the state enum type (IDLE/PRE/FORK/POST);
  - the delay word typedef parameterised on W, with default W=8.
- One sub-module, dly_branch, instanced twice for branches A and B:
  - inputs: load, value, abort;
  - outputs: one-cycle fire pulse and a sticky done flag;
  - it owns its down-counter.
- The pre/post counter stays in the top module.

Test Plan:
- Reset then idle: rstn low, then high; start=0 for 10 cycles -> all outputs 0, busy=0.
- Nominal run: P=0, A=10, B=15, Q=20, start at edge 0 -> pre_fire@1, a_fire@12, b_fire@17, done@38; busy high for edges 0..37.
- Equal branches and zero delays: P=A=B=Q=0 -> pre_fire@1, a_fire and b_fire both @2, done@3.
- Abort: nominal delays, abort high for one cycle at edge 14 -> busy=0 from edge 15; no b_fire and no done; a new start at edge 20 runs with full timing.
- Start while busy, then back-to-back: start pulses at edges 5 and 30 of the nominal run are ignored; start held high continuously is accepted again at edge 39 -> second done@77.
- Async reset mid-run: rstn low at edge 13 plus 3ns -> busy and all pulses 0 immediately; the nominal run repeated afterward has correct timing.
